// File: rtl/rv_mem_loader_if.sv
// Byte-stream and word-write bus of the program loader.
// master: the loader (consumes bytes, drives memory writes).
// slave:  the environment (byte source and memory).
interface rv_mem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  modport master (
    input  in_valid, in_data, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rv_mem_loader.sv
// Program loader: parses framed byte stream (MAGIC, addr, count, data, csum),
// writes little-endian words to memory and holds the core until the image
// is written and its checksum matches.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for MAGIC, other bytes discarded
// S_ADDR  | collecting 4 address bytes (LE)
// S_LEN   | collecting 4 word-count bytes (LE)
// S_DATA  | collecting 4 data bytes of the next word, summing checksum
// S_WRITE | mem_we high, bytes blocked until mem_ready
// S_CSUM  | waiting for the checksum byte
// S_DONE  | frame loaded, core released; MAGIC restarts
// S_ERROR | frame failed, core held; MAGIC restarts
module rv_mem_loader #(
  parameter logic [7:0] MAGIC       = 8'hA5,
  parameter int         TIMEOUT_CYC = 100000,
  parameter int         CNT_W       = 24
) (
  input  logic               clk,
  input  logic               rst,
  rv_mem_loader_if.master    bus,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [CNT_W-1:0]   words_written
);

  // Idle timer is a down-counter reloaded on each accepted byte; it expires
  // on the TIMEOUT_CYC-th consecutive idle cycle.
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLOAD = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t           state;
  logic [31:0]      shreg;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [7:0]       csum;
  logic [TW-1:0]    tmr;

  logic             byte_ok;
  logic             timing;
  logic             tmo;
  logic [31:0]      word_nxt;
  logic [31:0]      data_nxt;
  logic [CNT_W-1:0] ww_inc;

  // Handshake, little-endian assembly and timeout qualification.
  always_comb begin
    byte_ok  = bus.in_valid && bus.in_ready;
    timing   = (state == S_ADDR) || (state == S_LEN) ||
               (state == S_DATA) || (state == S_CSUM);
    tmo      = (TIMEOUT_CYC != 0) && timing && !byte_ok && (tmr == '0);
    word_nxt = {bus.in_data, shreg[31:8]};
    data_nxt = {bus.in_data, bus.mem_wdata[31:8]};
    ww_inc   = words_written + CNT_W'(1);
  end

  // Frame parser, write sequencer and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= 2'd0;
      words_written <= '0;
      shreg         <= '0;
      cnt           <= '0;
      idx           <= 2'd0;
      csum          <= 8'd0;
      tmr           <= TLOAD;
    end else begin
      if (byte_ok)
        tmr <= TLOAD;
      else if (timing && tmr != '0)
        tmr <= tmr - TW'(1);

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (byte_ok && bus.in_data == MAGIC) begin
            state         <= S_ADDR;
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= 2'd0;
            words_written <= '0;
            cpu_hold      <= 1'b1;
            idx           <= 2'd0;
            csum          <= 8'd0;
          end
        end
        S_ADDR: begin
          if (byte_ok) begin
            shreg <= word_nxt;
            idx   <= idx + 2'd1;
            if (idx == 2'd3) begin
              if (word_nxt[1:0] != 2'b00) begin
                state    <= S_ERROR;
                error    <= 1'b1;
                err_code <= 2'd1;
              end else begin
                bus.mem_addr <= word_nxt;
                state        <= S_LEN;
              end
            end
          end
        end
        S_LEN: begin
          if (byte_ok) begin
            shreg <= word_nxt;
            idx   <= idx + 2'd1;
            if (idx == 2'd3) begin
              cnt   <= word_nxt[CNT_W-1:0];
              state <= (word_nxt[CNT_W-1:0] == '0) ? S_CSUM : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (byte_ok) begin
            bus.mem_wdata <= data_nxt;
            csum          <= csum + bus.in_data;
            idx           <= idx + 2'd1;
            if (idx == 2'd3) begin
              state        <= S_WRITE;
              bus.mem_we   <= 1'b1;
              bus.in_ready <= 1'b0;
            end
          end
        end
        S_WRITE: begin
          if (bus.mem_ready) begin
            bus.mem_we    <= 1'b0;
            bus.in_ready  <= 1'b1;
            words_written <= ww_inc;
            bus.mem_addr  <= bus.mem_addr + 32'd4;
            state         <= (ww_inc == cnt) ? S_CSUM : S_DATA;
          end
        end
        S_CSUM: begin
          if (byte_ok) begin
            if (bus.in_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= S_ERROR;
              error    <= 1'b1;
              err_code <= 2'd2;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // tmo is only raised in collecting states with no byte this cycle,
      // so nothing above competes with it.
      if (tmo) begin
        state    <= S_ERROR;
        error    <= 1'b1;
        err_code <= 2'd3;
      end
    end
  end

endmodule

// File: tb/tb_rv_mem_loader.sv
// Bench for rv_mem_loader: directed frames plus random frames, checked every
// cycle against a frame-level model built from the byte queue of each frame.
module tb_rv_mem_loader;
  localparam int         TO    = 16;
  localparam logic [7:0] MAGIC = 8'hA5;
  localparam int         CNT_W = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_mem_loader_if bus();
  logic             cpu_hold, done, error;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] words_written;

  rv_mem_loader #(.MAGIC(MAGIC), .TIMEOUT_CYC(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cpu_hold(cpu_hold), .done(done), .error(error),
    .err_code(err_code), .words_written(words_written)
  );

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned gap_max = 0;
  int          mr_mode = 1;   // 0 random, 1 always ready, 2 never ready
  logic [7:0]  fq[$];
  logic [31:0] wl_addr[$];
  logic [31:0] wl_data[$];

  // frame-level model
  bit          m_live = 0, m_in_frame = 0, m_pend = 0;
  bit          m_done = 0, m_err = 0, m_hold = 1;
  logic [1:0]  m_code = 2'd0;
  int          m_ww = 0, m_cnt = 0, m_idle = 0;
  logic [31:0] m_base = 0, m_waddr = 0, m_wdata = 0;
  logic [7:0]  fb[$];

  task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_fail(input logic [1:0] c);
    m_in_frame = 0; m_err = 1; m_code = c; m_hold = 1; m_done = 0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    int n, k;
    logic [7:0] s;
    if (!m_in_frame) begin
      if (b == MAGIC) begin
        m_in_frame = 1; fb.delete();
        m_done = 0; m_err = 0; m_code = 2'd0; m_ww = 0; m_hold = 1;
      end
      return;
    end
    fb.push_back(b);
    n = fb.size();
    if (n == 4) begin
      m_base = {fb[3], fb[2], fb[1], fb[0]};
      if (m_base[1:0] != 2'b00) m_fail(2'd1);
    end else if (n == 8) begin
      m_cnt = int'({fb[7], fb[6], fb[5], fb[4]} & ((32'd1 << CNT_W) - 32'd1));
    end else if (n > 8) begin
      k = n - 8;
      if (k <= 4 * m_cnt) begin
        if (k % 4 == 0) begin
          m_pend  = 1;
          m_wdata = {fb[n-1], fb[n-2], fb[n-3], fb[n-4]};
          m_waddr = m_base + 32'(4 * (k / 4 - 1));
        end
      end else begin
        s = 8'd0;
        for (int i = 8; i < n - 1; i++) s = s + fb[i];
        if (s == b) begin
          m_in_frame = 0; m_done = 1; m_hold = 0;
        end else m_fail(2'd2);
      end
    end
  endtask

  // Advance the model across the coming clock edge (inputs are stable here).
  task automatic m_edge();
    bit acc, was_pend;
    if (rst) begin
      m_live = 1; m_in_frame = 0; m_pend = 0; m_done = 0; m_err = 0;
      m_code = 2'd0; m_hold = 1; m_ww = 0; m_idle = 0;
      return;
    end
    if (!m_live) return;
    was_pend = m_pend;
    acc = bus.in_valid && !m_pend;
    if (m_pend && bus.mem_ready) begin
      m_pend = 0; m_ww++;
    end
    if (acc) begin
      m_idle = 0;
      m_byte(bus.in_data);
    end else if (m_in_frame && !was_pend) begin
      m_idle++;
      if (m_idle == TO) m_fail(2'd3);
    end
  endtask

  // Per-cycle compare, write log and model step.
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        ck("in_ready", 32'(bus.in_ready), 32'(!m_pend));
        ck("mem_we", 32'(bus.mem_we), 32'(m_pend));
        if (m_pend) begin
          ck("mem_addr", bus.mem_addr, m_waddr);
          ck("mem_wdata", bus.mem_wdata, m_wdata);
        end
        ck("cpu_hold", 32'(cpu_hold), 32'(m_hold));
        ck("done", 32'(done), 32'(m_done));
        ck("error", 32'(error), 32'(m_err));
        ck("err_code", 32'(err_code), 32'(m_code));
        ck("words_written", 32'(words_written), 32'(m_ww));
      end
      if (!rst && bus.mem_we && bus.mem_ready) begin
        wl_addr.push_back(bus.mem_addr);
        wl_data.push_back(bus.mem_wdata);
      end
      m_edge();
    end
  end

  // Memory ready generator.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (mr_mode)
        0:       bus.mem_ready = 1'($urandom_range(0, 1));
        1:       bus.mem_ready = 1'b1;
        default: bus.mem_ready = 1'b0;
      endcase
    end
  end

  // Caller must be aligned at posedge+1; returns aligned at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 0;
    repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL send_byte: byte %h not accepted within 200 cycles", b);
    end
  endtask

  task automatic send_fq();
    @(posedge clk); #1;
    foreach (fq[i]) send_byte(fq[i]);
  endtask

  task automatic clear_log();
    wl_addr.delete(); wl_data.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    ck("rst_in_ready", 32'(bus.in_ready), 32'd1);
    ck("rst_mem_we", 32'(bus.mem_we), 32'd0);
    ck("rst_mem_addr", bus.mem_addr, 32'd0);
    ck("rst_mem_wdata", bus.mem_wdata, 32'd0);
    ck("rst_status", {27'd0, cpu_hold, done, error, err_code}, 32'b10000);
    ck("rst_ww", 32'(words_written), 32'd0);

    // basic load
    clear_log();
    fq = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
           8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
    send_fq();
    @(negedge clk);
    ck("basic_nwr", 32'(wl_addr.size()), 32'd2);
    ck("basic_a0", wl_addr[0], 32'h100);
    ck("basic_d0", wl_data[0], 32'h1);
    ck("basic_a1", wl_addr[1], 32'h104);
    ck("basic_d1", wl_data[1], 32'h2);
    ck("basic_status", {29'd0, done, cpu_hold, error}, 32'b100);
    ck("basic_ww", 32'(words_written), 32'd2);

    // checksum mismatch
    clear_log();
    fq[17] = 8'h04;
    send_fq();
    @(negedge clk);
    ck("csum_nwr", 32'(wl_addr.size()), 32'd2);
    ck("csum_status", {28'd0, done, cpu_hold, error, 1'b0}, 32'b0110);
    ck("csum_code", 32'(err_code), 32'd2);

    // misaligned address, trailing bytes ignored
    clear_log();
    fq = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
           8'h11, 8'h22, 8'h33, 8'h44};
    send_fq();
    @(negedge clk);
    ck("misal_nwr", 32'(wl_addr.size()), 32'd0);
    ck("misal_err", 32'(error), 32'd1);
    ck("misal_code", 32'(err_code), 32'd1);

    // memory backpressure
    clear_log();
    mr_mode = 2;
    fq = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
           8'h78, 8'h56, 8'h34, 8'h12};
    send_fq();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ck("bp_we", 32'(bus.mem_we), 32'd1);
      ck("bp_in_ready", 32'(bus.in_ready), 32'd0);
      ck("bp_addr", bus.mem_addr, 32'h200);
      ck("bp_data", bus.mem_wdata, 32'h12345678);
    end
    mr_mode = 1;
    fq = '{8'h14};
    send_fq();
    @(negedge clk);
    ck("bp_nwr", 32'(wl_addr.size()), 32'd1);
    ck("bp_done", 32'(done), 32'd1);

    // timeout after two data bytes, then zero-count restart
    fq = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
           8'hAA, 8'hBB};
    send_fq();
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (error) begin lat = i - 1; break; end
    end
    ck("timeout_latency", 32'(lat), 32'd16);
    ck("timeout_code", 32'(err_code), 32'd3);
    fq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_fq();
    @(negedge clk);
    ck("restart_status", {29'd0, done, error, cpu_hold}, 32'b100);
    ck("restart_ww", 32'(words_written), 32'd0);

    // reset during WRITE, then garbage and a good frame
    clear_log();
    mr_mode = 2;
    fq = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
           8'h11, 8'h22, 8'h33, 8'h44};
    send_fq();
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    ck("mrst_we", 32'(bus.mem_we), 32'd0);
    ck("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    ck("mrst_addr", bus.mem_addr, 32'd0);
    ck("mrst_status", {28'd0, cpu_hold, done, error, 1'b0}, 32'b1000);
    ck("mrst_nwr", 32'(wl_addr.size()), 32'd0);
    mr_mode = 0;
    fq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
           8'hBE, 8'hBA, 8'hFE, 8'hCA, 8'h40};
    send_fq();
    @(negedge clk);
    ck("mrst_frame_nwr", 32'(wl_addr.size()), 32'd1);
    ck("mrst_frame_a", wl_addr[0], 32'h300);
    ck("mrst_frame_d", wl_data[0], 32'hCAFEBABE);
    ck("mrst_frame_done", 32'(done), 32'd1);

    // address wrap, count upper byte ignored
    clear_log();
    fq = '{8'hA5, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h7E,
           8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
    send_fq();
    @(negedge clk);
    ck("wrap_nwr", 32'(wl_addr.size()), 32'd2);
    ck("wrap_a0", wl_addr[0], 32'hFFFFFFFC);
    ck("wrap_d0", wl_data[0], 32'h04030201);
    ck("wrap_a1", wl_addr[1], 32'h00000000);
    ck("wrap_d1", wl_data[1], 32'h08070605);
    ck("wrap_done", 32'(done), 32'd1);

    // random frames
    for (int f = 0; f < 12; f++) begin
      int nw;
      logic [31:0] a;
      logic [7:0] cs, tmp;
      bit bad;
      @(negedge clk);
      mr_mode = int'($urandom_range(0, 1));
      gap_max = $urandom_range(0, 2);
      nw  = int'($urandom_range(0, 3));
      a   = $urandom() & 32'hFFFF_FFFC;
      bad = ($urandom_range(0, 3) == 0);
      fq.delete();
      if ($urandom_range(0, 1) == 1) begin
        tmp = 8'($urandom_range(0, 255));
        if (tmp == MAGIC) tmp = 8'h00;
        fq.push_back(tmp);
      end
      fq.push_back(MAGIC);
      for (int i = 0; i < 4; i++) fq.push_back(a[8*i +: 8]);
      fq.push_back(8'(nw));
      fq.push_back(8'h00);
      fq.push_back(8'h00);
      fq.push_back(8'($urandom_range(0, 255)));
      cs = 8'h00;
      for (int i = 0; i < 4 * nw; i++) begin
        tmp = 8'($urandom_range(0, 255));
        cs  = cs + tmp;
        fq.push_back(tmp);
      end
      fq.push_back(bad ? cs + 8'h01 : cs);
      send_fq();
      @(negedge clk);
      ck("rand_status", {30'd0, done, error}, bad ? 32'b01 : 32'b10);
    end

    gap_max = 0;
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
